// File: rtl/tm_pkg.sv
// Shared types, constants and helpers for the tone-mapping stream alignment block.
package tm_pkg;

  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    WARMUP   = 2'd1,
    RUN      = 2'd2
  } tm_align_state_t;

  // Register stage plus divider pipeline of the tone-mapping stage.
  localparam int TM_DIV_LAT = 9;

  function automatic int tm_out_w(input int w);
    return w - 2;
  endfunction

endpackage

// File: rtl/sideband_delay.sv
// Generic fixed-depth shift register with asynchronous active-high clear.
module sideband_delay #(
  parameter int DEPTH = 9,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/tm_stream_align.sv
// Re-aligns sop/eop/valid with the tone-mapped pixel, gates warm-up frames,
// tracks framing errors and reports the pixel count of each completed frame.
//
// state    | meaning
// WAIT_SOP | idle after reset/resync, waiting for the first qualified sop
// WARMUP   | frames pass through tracking only; statistics not yet valid
// RUN      | frames whose sop arrives here are emitted on the output
module tm_stream_align
  import tm_pkg::*;
#(
  parameter int W             = 10,
  parameter int LAT           = TM_DIV_LAT,
  parameter int WARMUP_FRAMES = 1,
  parameter int CNT_W         = 22,
  localparam int OW           = tm_out_w(W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sop_i,
  input  logic             eop_i,
  input  logic             valid_i,
  input  logic [OW-1:0]    tm_data_i,
  input  logic             resync_i,
  output logic             sop_o,
  output logic             eop_o,
  output logic             valid_o,
  output logic [OW-1:0]    data_o,
  output logic             frame_done_o,
  output logic [CNT_W-1:0] pix_count_o,
  output logic             err_sop_o,
  output logic             err_eop_o
);

  if (LAT < 1 || LAT > 32) begin : g_bad_lat
    $error("tm_stream_align: LAT must be within 1..32");
  end
  if (WARMUP_FRAMES < 0 || WARMUP_FRAMES > 3) begin : g_bad_warmup
    $error("tm_stream_align: WARMUP_FRAMES must be within 0..3");
  end

  localparam logic [2:0] WF = 3'(WARMUP_FRAMES);

  logic [2:0] sb_d;
  logic       sop_d, eop_d, valid_d;
  logic       q_sop, q_eop;

  sideband_delay #(.DEPTH(LAT), .DW(3)) u_sb_delay (
    .clk  (clk),
    .rst  (reset),
    .din  ({sop_i, eop_i, valid_i}),
    .dout (sb_d)
  );

  assign {sop_d, eop_d, valid_d} = sb_d;
  assign q_sop = sop_d & valid_d;
  assign q_eop = eop_d & valid_d;

  tm_align_state_t state_q, state_n, eff;
  logic [1:0]       wcnt_q, wcnt_n;
  logic [2:0]       wsum;
  logic             in_frame_q, in_frame_n;
  logic             run_frame_q, run_frame_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc, pix_n;
  logic             done_n, err_sop_n, err_eop_n, eop_ok, en;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign wsum    = {1'b0, wcnt_q} + 3'd1;

  always_comb begin
    // The sop that leaves WAIT_SOP is processed as if already in the next state.
    eff = state_q;
    if (state_q == WAIT_SOP && q_sop) eff = (WF == 3'd0) ? RUN : WARMUP;

    state_n     = eff;
    wcnt_n      = wcnt_q;
    in_frame_n  = in_frame_q;
    run_frame_n = run_frame_q;
    cnt_n       = cnt_q;
    pix_n       = pix_count_o;
    done_n      = 1'b0;
    err_sop_n   = err_sop_o;
    err_eop_n   = err_eop_o;
    eop_ok      = 1'b0;
    en          = 1'b0;

    if (eff != WAIT_SOP) begin
      if (q_sop) begin
        if (in_frame_q) err_sop_n = 1'b1;
        cnt_n       = CNT_W'(1);
        in_frame_n  = ~q_eop;
        run_frame_n = (eff == RUN) & ~q_eop;
        en          = (eff == RUN);
        if (q_eop) begin
          pix_n  = CNT_W'(1);
          done_n = 1'b1;
          eop_ok = 1'b1;
        end
      end else if (q_eop) begin
        if (in_frame_q) begin
          cnt_n       = cnt_inc;
          pix_n       = cnt_inc;
          done_n      = 1'b1;
          eop_ok      = 1'b1;
          in_frame_n  = 1'b0;
          run_frame_n = 1'b0;
          en          = run_frame_q & (eff == RUN);
        end else begin
          err_eop_n = 1'b1;
        end
      end else if (valid_d && in_frame_q) begin
        cnt_n = cnt_inc;
        en    = run_frame_q & (eff == RUN);
      end

      if (eff == WARMUP && eop_ok) begin
        wcnt_n = wsum[1:0];
        if (wsum >= WF) state_n = RUN;
      end
    end

    // Resync drops the frame in progress but keeps the last reported count.
    if (resync_i) begin
      state_n     = WAIT_SOP;
      wcnt_n      = 2'd0;
      in_frame_n  = 1'b0;
      run_frame_n = 1'b0;
      cnt_n       = '0;
      pix_n       = pix_count_o;
      done_n      = 1'b0;
      err_sop_n   = 1'b0;
      err_eop_n   = 1'b0;
      en          = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_SOP;
      wcnt_q       <= 2'd0;
      in_frame_q   <= 1'b0;
      run_frame_q  <= 1'b0;
      cnt_q        <= '0;
      pix_count_o  <= '0;
      frame_done_o <= 1'b0;
      err_sop_o    <= 1'b0;
      err_eop_o    <= 1'b0;
      valid_o      <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      data_o       <= '0;
    end else begin
      state_q      <= state_n;
      wcnt_q       <= wcnt_n;
      in_frame_q   <= in_frame_n;
      run_frame_q  <= run_frame_n;
      cnt_q        <= cnt_n;
      pix_count_o  <= pix_n;
      frame_done_o <= done_n;
      err_sop_o    <= err_sop_n;
      err_eop_o    <= err_eop_n;
      valid_o      <= valid_d & en;
      sop_o        <= q_sop & en;
      eop_o        <= q_eop & en;
      data_o       <= (valid_d & en) ? tm_data_i : '0;
    end
  end

endmodule

// File: tb/tb_tm_stream_align.sv
// Directed bench for tm_stream_align: warm-up gating, latency, bubbles,
// framing errors, saturation, reset and resync.
module tb_tm_stream_align;

  localparam int W  = 10;
  localparam int OW = W - 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sop_i = 1'b0, eop_i = 1'b0, valid_i = 1'b0, resync_i = 1'b0;
  logic [OW-1:0] tm_data_i = '0;

  logic          sop_o, eop_o, valid_o, frame_done_o, err_sop_o, err_eop_o;
  logic [OW-1:0] data_o;
  logic [21:0]   pix_count_o;

  logic          s_sop_o, s_eop_o, s_valid_o, s_frame_done_o, s_err_sop_o, s_err_eop_o;
  logic [OW-1:0] s_data_o;
  logic [3:0]    s_pix_count_o;

  tm_stream_align #(.W(W), .LAT(9), .WARMUP_FRAMES(1), .CNT_W(22)) u_dut (
    .clk(clk), .reset(reset), .sop_i(sop_i), .eop_i(eop_i), .valid_i(valid_i),
    .tm_data_i(tm_data_i), .resync_i(resync_i), .sop_o(sop_o), .eop_o(eop_o),
    .valid_o(valid_o), .data_o(data_o), .frame_done_o(frame_done_o),
    .pix_count_o(pix_count_o), .err_sop_o(err_sop_o), .err_eop_o(err_eop_o)
  );

  tm_stream_align #(.W(W), .LAT(9), .WARMUP_FRAMES(1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .sop_i(sop_i), .eop_i(eop_i), .valid_i(valid_i),
    .tm_data_i(tm_data_i), .resync_i(resync_i), .sop_o(s_sop_o), .eop_o(s_eop_o),
    .valid_o(s_valid_o), .data_o(s_data_o), .frame_done_o(s_frame_done_o),
    .pix_count_o(s_pix_count_o), .err_sop_o(s_err_sop_o), .err_eop_o(s_err_eop_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int t = 0;
  int n_vo, n_sop, n_done, first_vo;
  logic       vo_hist [0:4095];
  logic       vi_hist [0:4095];
  logic [7:0] do_hist [0:4095];
  logic [7:0] dpipe   [0:8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    n_vo = 0; n_sop = 0; n_done = 0; first_vo = -1;
  endtask

  // One input slot; the bench plays the divider, presenting each pixel 9 slots later.
  task automatic step(input logic s, input logic e, input logic v, input logic [7:0] d);
    sop_i = s; eop_i = e; valid_i = v;
    tm_data_i = dpipe[8];
    for (int i = 8; i > 0; i--) dpipe[i] = dpipe[i-1];
    dpipe[0] = v ? d : 8'hEE;
    vi_hist[t] = v;
    @(posedge clk); #1;
    t++;
    vo_hist[t] = valid_o;
    do_hist[t] = data_o;
    if (valid_o) begin
      n_vo++;
      if (first_vo < 0) first_vo = t;
    end
    if (sop_o) n_sop++;
    if (frame_done_o) n_done++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int n, input logic [7:0] d0);
    for (int i = 0; i < n; i++) step(i == 0, i == n - 1, 1'b1, d0 + 8'(i));
  endtask

  task automatic resync_pulse();
    resync_i = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    resync_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    int a, b, s, mism;
    for (int i = 0; i < 9; i++) dpipe[i] = 8'hEE;
    clr_mon();
    #2 reset = 1'b1;
    idle(3);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_pix_count", pix_count_o, 0);
    chk("rst_errors", {err_sop_o, err_eop_o, frame_done_o}, 0);
    reset = 1'b0;
    idle(2);

    // Warm-up: first frame suppressed, second emitted with LAT+1 latency.
    clr_mon();
    a = t; send_frame(16, 8'h10); idle(2);
    b = t; send_frame(16, 8'h40); idle(12);
    chk("wu_first_vo", first_vo, b + 10);
    chk("wu_n_vo", n_vo, 16);
    chk("wu_n_sop", n_sop, 1);
    chk("wu_done", n_done, 2);
    chk("wu_pix", pix_count_o, 16);
    chk("wu_data", do_hist[b+10], 8'h40);

    // Latency and data gating.
    clr_mon();
    s = t;
    step(1'b1, 1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 1'b1, 8'h5A);
    idle(12);
    chk("lat_valid", vo_hist[s+10], 1);
    chk("lat_data", do_hist[s+10], 8'hA5);
    chk("lat_data2", do_hist[s+11], 8'h5A);
    chk("lat_idle_after", do_hist[s+12], 0);
    chk("lat_idle_before", do_hist[s+9], 0);
    chk("lat_pix", pix_count_o, 2);

    // Bubbles, with sop/eop on invalid beats that must be ignored.
    clr_mon();
    s = t;
    for (int k = 0; k < 32; k++)
      step(k == 0 || k == 5, k == 30 || k == 9, (k % 2) == 0, 8'(k));
    idle(12);
    mism = 0;
    for (int k = 0; k < 32; k++)
      if (vo_hist[s+k+10] !== vi_hist[s+k]) mism++;
    chk("bub_pattern", mism, 0);
    chk("bub_pix", pix_count_o, 16);
    chk("bub_n_sop", n_sop, 1);
    chk("bub_done", n_done, 1);
    chk("bub_errors", {err_sop_o, err_eop_o}, 0);

    // Framing errors.
    clr_mon();
    step(1'b1, 1'b0, 1'b1, 8'h01);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'h02);
    step(1'b1, 1'b0, 1'b1, 8'h03);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 8'h04);
    step(1'b0, 1'b1, 1'b1, 8'h05);
    idle(12);
    chk("fe_err_sop", err_sop_o, 1);
    chk("fe_err_eop0", err_eop_o, 0);
    chk("fe_pix_restart", pix_count_o, 4);
    chk("fe_done", n_done, 1);
    clr_mon();
    step(1'b0, 1'b1, 1'b1, 8'h06);
    idle(12);
    chk("fe_err_eop", err_eop_o, 1);
    chk("fe_no_done", n_done, 0);
    chk("fe_pix_kept", pix_count_o, 4);
    resync_pulse();
    chk("fe_resync_clear", {err_sop_o, err_eop_o}, 0);
    idle(2);

    // Single-pixel frame; a following lone eop proves in_frame stayed low.
    clr_mon();
    step(1'b1, 1'b1, 1'b1, 8'h07);
    idle(12);
    chk("sp_pix", pix_count_o, 1);
    chk("sp_done", n_done, 1);
    chk("sp_warmup_no_out", n_vo, 0);
    step(1'b0, 1'b1, 1'b1, 8'h08);
    idle(12);
    chk("sp_in_frame_low", err_eop_o, 1);
    resync_pulse();
    idle(2);

    // Saturation: 20 pixels into a 4-bit counter.
    clr_mon();
    send_frame(20, 8'h20);
    idle(12);
    chk("sat_pix_wide", pix_count_o, 20);
    chk("sat_pix_4b", s_pix_count_o, 15);
    chk("sat_warmup_no_out", n_vo, 0);

    // Asynchronous reset in the middle of a RUN frame.
    clr_mon();
    for (int k = 0; k < 14; k++) step(k == 0, 1'b0, 1'b1, 8'h60 + 8'(k));
    chk("mr_pre_valid", valid_o, 1);
    #3 reset = 1'b1;
    #1;
    chk("mr_async_valid", valid_o, 0);
    chk("mr_async_data", data_o, 0);
    chk("mr_async_pix", pix_count_o, 0);
    idle(2);
    reset = 1'b0;
    idle(2);
    clr_mon();
    send_frame(16, 8'h10); idle(2);
    b = t; send_frame(16, 8'h30); idle(12);
    chk("mr_first_vo", first_vo, b + 10);
    chk("mr_n_vo", n_vo, 16);
    chk("mr_pix", pix_count_o, 16);

    // Resync in the middle of a RUN frame.
    clr_mon();
    s = t;
    for (int k = 0; k < 20; k++) begin
      if (k == 14) resync_i = 1'b1;
      step(k == 0, k == 19, 1'b1, 8'h70 + 8'(k));
      resync_i = 1'b0;
    end
    idle(12);
    chk("rs_last_valid", vo_hist[s+14], 1);
    chk("rs_stop_valid", vo_hist[s+15], 0);
    chk("rs_n_vo", n_vo, 5);
    chk("rs_no_done", n_done, 0);
    chk("rs_pix_kept", pix_count_o, 16);
    clr_mon();
    send_frame(16, 8'h10); idle(2);
    b = t; send_frame(16, 8'h50); idle(12);
    chk("rs_first_vo", first_vo, b + 10);
    chk("rs_n_vo_after", n_vo, 16);
    chk("rs_done_after", n_done, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
